// File: rtl/vote_pkg.sv
// Shared types and constants for the weighted-vote decision path.
// Tally weights mirror the upstream tally stage so the legal range is derived, not restated.
package vote_pkg;

  localparam int TALLY_W = 8;

  localparam int W_NP   = 1;
  localparam int W_VIP  = 4;
  localparam int W_VVIP = 16;
  localparam int N_NP   = 32;
  localparam int N_VIP  = 8;

  localparam int MAX_TALLY = N_NP * W_NP + N_VIP * W_VIP + W_VVIP;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    OPEN = 2'd2,
    DONE = 2'd3
  } state_t;

  // A tally that drops or exceeds the legal maximum means the tally stage misbehaved.
  function automatic logic tally_bad(input logic [TALLY_W-1:0] cur,
                                     input logic [TALLY_W-1:0] last,
                                     input logic [TALLY_W-1:0] max_legal);
    return (cur < last) || (cur > max_legal);
  endfunction

endpackage

// File: rtl/vote_timer.sv
// Saturating elapsed-cycle counter for an open voting window, with a timeout-hit compare.
module vote_timer #(
  parameter int EW      = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [EW-1:0] o_elapsed,
  output logic          o_hit
);

  localparam logic [EW-1:0] LP_LAST = EW'(TIMEOUT - 1);

  logic [EW-1:0] r_elapsed;

  // Count enabled cycles, holding at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_elapsed <= '0;
    end else if (i_clr) begin
      r_elapsed <= '0;
    end else if (i_en && (r_elapsed != {EW{1'b1}})) begin
      r_elapsed <= r_elapsed + EW'(1);
    end
  end

  assign o_elapsed = r_elapsed;
  assign o_hit     = (TIMEOUT != 0) && (r_elapsed == LP_LAST);

endmodule

// File: rtl/vote_decider.sv
// Voting session controller: clears the tally stage, opens a window and declares pass/fail/err.
// Every output is a register loaded from the next-state decision, so nothing is combinational from inputs.
module vote_decider
  import vote_pkg::*;
#(
  parameter int THRESH    = 41,
  parameter int MAX_TALLY = vote_pkg::MAX_TALLY,
  parameter int TIMEOUT   = 1000,
  parameter int EW        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               close,
  input  logic [TALLY_W-1:0] tally,
  output logic               voter_clr,
  output logic               voting_open,
  output logic               done_pulse,
  output logic               decided,
  output logic               pass,
  output logic               fail,
  output logic               err,
  output logic [TALLY_W-1:0] final_tally,
  output logic [EW-1:0]      elapsed
);

  localparam logic [TALLY_W-1:0] LP_THRESH = TALLY_W'(THRESH);
  localparam logic [TALLY_W-1:0] LP_MAX    = TALLY_W'(MAX_TALLY);

  if (THRESH > MAX_TALLY) begin : g_thresh_chk
    $error("vote_decider: THRESH must not exceed MAX_TALLY");
  end
  if (MAX_TALLY > 255) begin : g_max_chk
    $error("vote_decider: MAX_TALLY must fit in 8 bits");
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_err;
  logic               w_pass_hit;
  logic               w_fail_hit;
  logic               w_arm;
  logic               w_exit;
  logic               w_tmr_en;
  logic               w_timeout_hit;
  logic [EW-1:0]      w_elapsed;

  logic               r_voter_clr;
  logic               r_voting_open;
  logic               r_done_pulse;
  logic               r_decided;
  logic               r_pass;
  logic               r_fail;
  logic               r_err;
  logic [TALLY_W-1:0] r_final_tally;
  logic [TALLY_W-1:0] r_last_tally;

  // Next-state and decision priority: error beats pass, pass beats close/timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_pass_hit  = 1'b0;
    w_fail_hit  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = ARM;
        else       w_state_nxt = IDLE;
      end
      ARM: begin
        w_state_nxt = OPEN;
      end
      OPEN: begin
        w_err      = tally_bad(tally, r_last_tally, LP_MAX);
        w_pass_hit = !w_err && (tally >= LP_THRESH);
        w_fail_hit = !w_err && !w_pass_hit && (close || w_timeout_hit);
        if (w_err || w_pass_hit || w_fail_hit) w_state_nxt = DONE;
        else                                   w_state_nxt = OPEN;
      end
      DONE: begin
        if (start) w_state_nxt = ARM;
        else       w_state_nxt = DONE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_arm    = (w_state_nxt == ARM);
  assign w_exit   = (r_state == OPEN) && (w_state_nxt == DONE);
  assign w_tmr_en = (r_state == OPEN) && (w_state_nxt == OPEN);

  vote_timer #(
    .EW      (EW),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .i_rst_n   (reset),
    .i_clr     (w_arm),
    .i_en      (w_tmr_en),
    .o_elapsed (w_elapsed),
    .o_hit     (w_timeout_hit)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Output and history registers, loaded from the decision made this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_voter_clr   <= 1'b0;
      r_voting_open <= 1'b0;
      r_done_pulse  <= 1'b0;
      r_decided     <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_err         <= 1'b0;
      r_final_tally <= '0;
      r_last_tally  <= '0;
    end else begin
      r_voter_clr   <= w_arm;
      r_voting_open <= (w_state_nxt == OPEN);
      r_decided     <= (w_state_nxt == DONE);
      r_done_pulse  <= w_exit;
      if (w_arm) begin
        r_pass        <= 1'b0;
        r_fail        <= 1'b0;
        r_err         <= 1'b0;
        r_final_tally <= '0;
        r_last_tally  <= '0;
      end else if (w_exit) begin
        r_pass        <= w_pass_hit;
        r_fail        <= w_fail_hit;
        r_err         <= w_err;
        r_final_tally <= tally;
      end else if (w_tmr_en) begin
        r_last_tally  <= tally;
      end
    end
  end

  assign voter_clr   = r_voter_clr;
  assign voting_open = r_voting_open;
  assign done_pulse  = r_done_pulse;
  assign decided     = r_decided;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign err         = r_err;
  assign final_tally = r_final_tally;
  assign elapsed     = w_elapsed;

endmodule

// File: tb/tb_vote_decider.sv
// Directed bench for vote_decider: default, TIMEOUT=5 and TIMEOUT=0 instances share one stimulus.
// Status vectors are {voter_clr, voting_open, done_pulse, decided, pass, fail, err}.
module tb_vote_decider;

  logic       clk;
  logic       reset;
  logic       start;
  logic       close;
  logic [7:0] tally;

  logic       d_clr, d_open, d_pulse, d_dec, d_pass, d_fail, d_err;
  logic [7:0] d_final;
  logic [15:0] d_elapsed;
  logic       f_clr, f_open, f_pulse, f_dec, f_pass, f_fail, f_err;
  logic [7:0] f_final;
  logic [15:0] f_elapsed;
  logic       z_clr, z_open, z_pulse, z_dec, z_pass, z_fail, z_err;
  logic [7:0] z_final;
  logic [15:0] z_elapsed;

  logic [6:0] d_st, f_st, z_st;
  assign d_st = {d_clr, d_open, d_pulse, d_dec, d_pass, d_fail, d_err};
  assign f_st = {f_clr, f_open, f_pulse, f_dec, f_pass, f_fail, f_err};
  assign z_st = {z_clr, z_open, z_pulse, z_dec, z_pass, z_fail, z_err};

  localparam logic [6:0] ST_IDLE   = 7'b0000000;
  localparam logic [6:0] ST_ARM    = 7'b1000000;
  localparam logic [6:0] ST_OPEN   = 7'b0100000;
  localparam logic [6:0] ST_PASS_E = 7'b0011100;
  localparam logic [6:0] ST_PASS_H = 7'b0001100;
  localparam logic [6:0] ST_FAIL_E = 7'b0011010;
  localparam logic [6:0] ST_FAIL_H = 7'b0001010;
  localparam logic [6:0] ST_ERR_E  = 7'b0011001;

  int n_cmp;
  int n_bad;

  vote_decider #(.THRESH(41), .MAX_TALLY(80), .TIMEOUT(1000), .EW(16)) u_def (
    .clk(clk), .reset(reset), .start(start), .close(close), .tally(tally),
    .voter_clr(d_clr), .voting_open(d_open), .done_pulse(d_pulse), .decided(d_dec),
    .pass(d_pass), .fail(d_fail), .err(d_err), .final_tally(d_final), .elapsed(d_elapsed)
  );

  vote_decider #(.THRESH(41), .MAX_TALLY(80), .TIMEOUT(5), .EW(16)) u_t5 (
    .clk(clk), .reset(reset), .start(start), .close(close), .tally(tally),
    .voter_clr(f_clr), .voting_open(f_open), .done_pulse(f_pulse), .decided(f_dec),
    .pass(f_pass), .fail(f_fail), .err(f_err), .final_tally(f_final), .elapsed(f_elapsed)
  );

  vote_decider #(.THRESH(41), .MAX_TALLY(80), .TIMEOUT(0), .EW(16)) u_t0 (
    .clk(clk), .reset(reset), .start(start), .close(close), .tally(tally),
    .voter_clr(z_clr), .voting_open(z_open), .done_pulse(z_pulse), .decided(z_dec),
    .pass(z_pass), .fail(z_fail), .err(z_err), .final_tally(z_final), .elapsed(z_elapsed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pure stimulus: from a negedge, pulse start and return at the first OPEN negedge.
  task automatic open_session();
    start = 1'b1;
    close = 1'b0;
    tally = 8'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (d_st !== ST_IDLE) begin n_bad++; $display("FAIL reset_status: got %b want %b", d_st, ST_IDLE); end
    n_cmp++;
    if ({d_final, d_elapsed} !== 24'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {d_final, d_elapsed}); end
    n_cmp++;
    if (f_st !== ST_IDLE) begin n_bad++; $display("FAIL reset_status_t5: got %b want %b", f_st, ST_IDLE); end
    reset = 1'b1;
    close = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (d_st !== ST_IDLE) begin n_bad++; $display("FAIL idle_close_ignored: got %b want %b", d_st, ST_IDLE); end
  endtask

  task automatic test_arm();
    start = 1'b1;
    close = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (d_st !== ST_ARM) begin n_bad++; $display("FAIL arm_status: got %b want %b", d_st, ST_ARM); end
    start = 1'b0;
    close = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (d_st !== ST_OPEN) begin n_bad++; $display("FAIL open_status: got %b want %b", d_st, ST_OPEN); end
    n_cmp++;
    if (d_elapsed !== 16'd0) begin n_bad++; $display("FAIL open_elapsed: got %0d want 0", d_elapsed); end
  endtask

  task automatic test_pass();
    logic [7:0] steps [5];
    steps = '{8'd0, 8'd4, 8'd20, 8'd40, 8'd41};
    for (int i = 0; i < 5; i++) begin
      tally = steps[i];
      @(negedge clk);
      if (i < 4) begin
        n_cmp++;
        if (d_st !== ST_OPEN || d_elapsed !== 16'(i + 1)) begin
          n_bad++;
          $display("FAIL pass_step%0d: got st=%b el=%0d want st=%b el=%0d", i, d_st, d_elapsed, ST_OPEN, i + 1);
        end
      end
    end
    n_cmp++;
    if (d_st !== ST_PASS_E) begin n_bad++; $display("FAIL pass_entry: got %b want %b", d_st, ST_PASS_E); end
    n_cmp++;
    if (d_final !== 8'd41 || d_elapsed !== 16'd4) begin
      n_bad++; $display("FAIL pass_data: got final=%0d el=%0d want final=41 el=4", d_final, d_elapsed);
    end
    n_cmp++;
    if (f_st !== ST_PASS_E) begin n_bad++; $display("FAIL pass_beats_timeout: got %b want %b", f_st, ST_PASS_E); end
    @(negedge clk);
    n_cmp++;
    if (d_st !== ST_PASS_H) begin n_bad++; $display("FAIL pass_hold: got %b want %b", d_st, ST_PASS_H); end
  endtask

  task automatic test_close();
    start = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (d_st !== ST_ARM || d_final !== 8'd0) begin
      n_bad++; $display("FAIL rearm_clear: got st=%b final=%0d want st=%b final=0", d_st, d_final, ST_ARM);
    end
    start = 1'b0;
    @(negedge clk);
    tally = 8'd30;
    close = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (d_st !== ST_FAIL_E || d_final !== 8'd30) begin
      n_bad++; $display("FAIL close_fail: got st=%b final=%0d want st=%b final=30", d_st, d_final, ST_FAIL_E);
    end
    tally = 8'd50;
    @(negedge clk);
    n_cmp++;
    if (d_st !== ST_FAIL_H || d_final !== 8'd30) begin
      n_bad++; $display("FAIL done_close_ignored: got st=%b final=%0d want st=%b final=30", d_st, d_final, ST_FAIL_H);
    end
    close = 1'b0;
    start = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (d_fail !== 1'b0 || d_dec !== 1'b0) begin
      n_bad++; $display("FAIL rearm_clears_fail: got fail=%b dec=%b want 0 0", d_fail, d_dec);
    end
    start = 1'b0;
    @(negedge clk);
    close = 1'b1;
    @(negedge clk);
    close = 1'b0;
  endtask

  task automatic test_timeout();
    int c;
    logic z_left_open;
    c = 0;
    z_left_open = 1'b0;
    open_session();
    tally = 8'd10;
    while (f_dec !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (c !== 5) begin n_bad++; $display("FAIL t5_cycles: got %0d want 5", c); end
    n_cmp++;
    if (f_st !== ST_FAIL_E || f_elapsed !== 16'd4 || f_final !== 8'd10) begin
      n_bad++; $display("FAIL t5_result: got st=%b el=%0d final=%0d want st=%b el=4 final=10", f_st, f_elapsed, f_final, ST_FAIL_E);
    end
    for (int i = c; i < 2000; i++) begin
      @(negedge clk);
      if (z_st !== ST_OPEN) z_left_open = 1'b1;
    end
    n_cmp++;
    if (z_left_open !== 1'b0 || z_elapsed !== 16'd2000) begin
      n_bad++; $display("FAIL t0_no_timeout: got left=%b el=%0d want left=0 el=2000", z_left_open, z_elapsed);
    end
    n_cmp++;
    if (d_st !== ST_FAIL_H || d_elapsed !== 16'd999) begin
      n_bad++; $display("FAIL t1000_result: got st=%b el=%0d want st=%b el=999", d_st, d_elapsed, ST_FAIL_H);
    end
    close = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (z_st !== ST_FAIL_E) begin n_bad++; $display("FAIL t0_close: got %b want %b", z_st, ST_FAIL_E); end
    close = 1'b0;
  endtask

  task automatic test_errors();
    open_session();
    tally = 8'd20;
    @(negedge clk);
    tally = 8'd16;
    @(negedge clk);
    n_cmp++;
    if (d_st !== ST_ERR_E || d_final !== 8'd16) begin
      n_bad++; $display("FAIL err_nonmono: got st=%b final=%0d want st=%b final=16", d_st, d_final, ST_ERR_E);
    end
    open_session();
    tally = 8'd81;
    @(negedge clk);
    n_cmp++;
    if (d_st !== ST_ERR_E || d_final !== 8'd81) begin
      n_bad++; $display("FAIL err_range: got st=%b final=%0d want st=%b final=81", d_st, d_final, ST_ERR_E);
    end
  endtask

  task automatic test_pass_close();
    open_session();
    tally = 8'd40;
    @(negedge clk);
    n_cmp++;
    if (d_st !== ST_OPEN) begin n_bad++; $display("FAIL below_thresh: got %b want %b", d_st, ST_OPEN); end
    tally = 8'd41;
    close = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (d_st !== ST_PASS_E) begin n_bad++; $display("FAIL pass_over_close: got %b want %b", d_st, ST_PASS_E); end
    close = 1'b0;
  endtask

  task automatic test_reset_mid();
    open_session();
    tally = 8'd5;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (d_st !== ST_IDLE || d_elapsed !== 16'd0 || d_final !== 8'd0) begin
      n_bad++; $display("FAIL async_reset: got st=%b el=%0d final=%0d want all 0", d_st, d_elapsed, d_final);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (d_st !== ST_IDLE) begin n_bad++; $display("FAIL post_reset_idle: got %b want %b", d_st, ST_IDLE); end
    start = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (d_st !== ST_ARM) begin n_bad++; $display("FAIL post_reset_arm: got %b want %b", d_st, ST_ARM); end
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (d_st !== ST_OPEN || d_elapsed !== 16'd0) begin
      n_bad++; $display("FAIL post_reset_open: got st=%b el=%0d want st=%b el=0", d_st, d_elapsed, ST_OPEN);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    start = 1'b0;
    close = 1'b0;
    tally = 8'd0;
    test_reset();
    test_arm();
    test_pass();
    test_close();
    test_timeout();
    test_errors();
    test_pass_close();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vote_decider.md
Name: vote_decider

Overview:
- Downstream consumer of the weighted vote tally stage (32 normal voters ×1, 8 VIP ×4, 1 VVIP ×16; tally range 0..80, registered, monotonic non-decreasing within a session).
- Runs a voting session: clears the tally stage, opens a window, watches the tally, and declares pass/fail/error. Pass is declared on threshold. Fail is declared on close or timeout.
- Drives the tally stage's active-high clear through voter_clr.

Parameters:
- THRESH, 41, pass threshold; pass when tally >= THRESH.
- MAX_TALLY, 80, largest legal tally; any larger value is an error.
- TIMEOUT, 1000, session length in OPEN cycles; 0 disables the timeout.
- EW, 16, width of the elapsed counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; reset==0 forces the reset state immediately.
- start  input  1  level-sampled request to open a new session.
- close  input  1  level-sampled request to end the session early.
- tally  input  8  weighted vote total from the tally stage.
- voter_clr  output  1  one-cycle active-high clear to the tally stage.
- voting_open  output  1  high while state==OPEN.
- done_pulse  output  1  one-cycle pulse on entry to DONE.
- decided  output  1  high while state==DONE.
- pass  output  1  valid when decided.
- fail  output  1  valid when decided.
- err  output  1  valid when decided; set for a non-monotonic or out-of-range tally.
- final_tally  output  8  tally captured on the decision cycle.
- elapsed  output  EW  number of OPEN cycles consumed.

Behaviour:
- Reset (reset==0, async): state=IDLE. All outputs 0. Internal last_tally=0.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states: IDLE, ARM, OPEN, DONE.
- IDLE:
  - start=1 -> ARM.
  - close is ignored. If start and close are both 1, start wins.
- ARM (exactly 1 cycle):
  - voter_clr=1 this cycle.
  - elapsed, last_tally, pass, fail, err and final_tally cleared to 0.
  - -> OPEN unconditionally.
  - tally is ignored in ARM. Its first valid sample is on the first OPEN cycle, because the tally stage clears asynchronously.
- OPEN, evaluated every cycle in this priority:
  1. Error: tally < last_tally or tally > MAX_TALLY -> DONE with err=1, pass=0, fail=0.
  2. Pass: tally >= THRESH -> DONE with pass=1.
  3. Fail: close=1, or TIMEOUT!=0 and elapsed==TIMEOUT-1 -> DONE with fail=1.
  4. Otherwise: stay in OPEN, last_tally<=tally, elapsed<=elapsed+1 (saturating at all-ones).
- On any exit from OPEN: final_tally<=tally sampled that cycle, and done_pulse=1 on the next cycle only.
- Threshold reached and close asserted in the same cycle -> pass, not fail.
- start asserted while in OPEN is ignored.
- DONE:
  - Outputs hold. close is ignored.
  - start=1 -> ARM, which re-clears outputs (decided drops in ARM).
- Latency: a tally presented on cycle N gives decided=1 and done_pulse=1 visible after edge N+1.
- Exactly one of pass/fail/err is 1 whenever decided=1.
- Reset asserted mid-session aborts the session with no done_pulse. The tally stage is not cleared by this block in that case; the next start issues voter_clr.
- Arithmetic: comparisons are unsigned 8-bit. THRESH and MAX_TALLY must be <= 255; elaboration-time assertion that THRESH <= MAX_TALLY.

Decomposition:
- Shared package vote_pkg holds:
  - state enum {IDLE, ARM, OPEN, DONE};
  - weight constants W_NP=1, W_VIP=4, W_VVIP=16;
  - N_NP=32, N_VIP=8, MAX_TALLY=80;
  - TALLY_W=8.
- One natural sub-module: vote_timer, the saturating elapsed counter with clear/enable and a timeout-hit compare.
- The FSM and decision logic stay in vote_decider.

Test Plan:
- Reset, then start=1 for 1 cycle -> voter_clr=1 for exactly one cycle. Next cycle voting_open=1, elapsed=0.
- In OPEN, tally steps 0,4,20,40,41 -> on the cycle after tally=41: decided=1, pass=1, done_pulse=1 for one cycle, final_tally=41.
- In OPEN with tally=30, close=1 -> fail=1, final_tally=30. A later close in DONE changes nothing. start then re-arms and clears fail.
- TIMEOUT=5, tally held at 10 -> fail after 5 OPEN cycles, elapsed=4, final_tally=10. With TIMEOUT=0 the session never times out over 2000 cycles.
- Non-monotonic and out-of-range errors:
  - tally 20 then 16 -> err=1, pass=0, fail=0, final_tally=16.
  - separately, tally=81 -> err=1.
  - tally=41 with close=1 in the same cycle -> pass=1.
- reset driven 0 in the middle of OPEN -> all outputs 0 immediately, no done_pulse, state IDLE. start after release -> normal ARM/OPEN sequence.
